intersection_phase_scheduler: RTL and testbench

Multi-approach traffic-light phase scheduler for the lab5 intersection work. It arbitrates green time among `N_APP` approaches using per-approach car sensors. It enforces minimum green, gap-extended maximum green, yellow and all-red clearance intervals, and drives one 3-bit lamp group per approach. It generalises the two-road highway/local-road controller into a round-robin scheduler and shares the same lamp encoding.

---
 rtl/traffic_pkg.sv | 15 +
 rtl/tl_rr_picker.sv | 32 +++
 rtl/intersection_phase_scheduler.sv | 122 ++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encoding and phase states for the traffic-light controllers.
// Lamp groups are one-hot: green, yellow, red from msb to lsb.
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_e;

endpackage

// File: rtl/tl_rr_picker.sv
// Round-robin first-set finder: scans req from start upward, wrapping
// modulo N, and reports the first set index.
module tl_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] win,
    output logic         valid
);

    function automatic logic [W-1:0] wrap(input logic [W-1:0] s, input int k);
        int t;
        t = int'(s) + k;
        if (t >= N) t = t - N;
        return W'(t);
    endfunction

    // Scan from the far end so the closest set bit overwrites last.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(start, k)]) begin
                win   = wrap(start, k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin green-time scheduler over N_APP approaches with min/max
// green, gap-out, yellow and all-red clearance.
import traffic_pkg::*;

module intersection_phase_scheduler #(
    parameter int N_APP     = 4,
    parameter int GREEN_MIN = 30,
    parameter int GREEN_MAX = 70,
    parameter int YELLOW    = 25,
    parameter int ALL_RED   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_APP-1:0]         car_req,
    output logic [3*N_APP-1:0]       lights,
    output logic [$clog2(N_APP)-1:0] cur_app,
    output logic [N_APP-1:0]         pending,
    output logic                     phase_start
);

    localparam int AW = $clog2(N_APP);
    localparam int CW = $clog2(GREEN_MAX);

    phase_e          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   nxt_app;
    logic [AW-1:0]   start;
    logic [AW-1:0]   win;
    logic            pick_ok;
    logic            others;
    logic            cnt_max;
    logic            go_yel;
    logic            yel_done;
    logic            red_done;
    logic [N_APP-1:0] cur_mask;
    logic [N_APP-1:0] pend_nx;

    assign cur_mask = N_APP'(1) << cur_app;
    assign others   = |(pending & ~cur_mask);
    assign start    = (cur_app == AW'(N_APP - 1)) ? '0 : cur_app + 1'b1;
    assign cnt_max  = (cnt == CW'(GREEN_MAX - 1));

    assign go_yel = (state == PH_GREEN) && others && pick_ok &&
                    (cnt >= CW'(GREEN_MIN - 1)) &&
                    (!car_req[cur_app] || cnt_max);
    assign yel_done = (state == PH_YELLOW) && (cnt == CW'(YELLOW - 1));
    assign red_done = (state == PH_ALL_RED) && (cnt == CW'(ALL_RED - 1));

    tl_rr_picker #(
        .N (N_APP),
        .W (AW)
    ) u_pick (
        .req   (pending),
        .start (start),
        .win   (win),
        .valid (pick_ok)
    );

    // The owner's own sensor only extends its green, it never queues it.
    always_comb begin
        pend_nx = pending | car_req;
        if (state == PH_GREEN) pend_nx[cur_app] = 1'b0;
        if (red_done) pend_nx[nxt_app] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PH_GREEN;
            cur_app <= '0;
            nxt_app <= '0;
            cnt     <= '0;
            pending <= '0;
        end else begin
            pending <= pend_nx;
            unique case (state)
                PH_GREEN: begin
                    if (go_yel) begin
                        state   <= PH_YELLOW;
                        cnt     <= '0;
                        nxt_app <= win;
                    end else if (!cnt_max) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (yel_done) begin
                        state <= PH_ALL_RED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_ALL_RED: begin
                    if (red_done) begin
                        state   <= PH_GREEN;
                        cur_app <= nxt_app;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= PH_ALL_RED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // cnt is only zero in GREEN on its first cycle.
    always_comb begin
        lights      = {N_APP{LIGHT_RED}};
        phase_start = 1'b0;
        if (state == PH_GREEN) begin
            lights[3*cur_app +: 3] = LIGHT_GREEN;
            phase_start            = (cnt == '0);
        end else if (state == PH_YELLOW) begin
            lights[3*cur_app +: 3] = LIGHT_YELLOW;
        end
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler; lamp-change events are
// checked against a queue of hand-computed expectations.
module tb_intersection_phase_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  car_req = '0;
    logic [11:0] lights;
    logic [1:0]  cur_app;
    logic [3:0]  pending;
    logic        phase_start;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base  = 0;

    typedef struct {
        int          c;
        int          app;
        logic [11:0] lt;
        logic        ps;
    } ev_t;

    ev_t         evq[$];
    logic [11:0] prev_lt;

    intersection_phase_scheduler #(
        .N_APP     (4),
        .GREEN_MIN (30),
        .GREEN_MAX (70),
        .YELLOW    (25),
        .ALL_RED   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .car_req     (car_req),
        .lights      (lights),
        .cur_app     (cur_app),
        .pending     (pending),
        .phase_start (phase_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] lg(input int a);
        logic [11:0] r;
        r = {4{3'b001}};
        r[3*a +: 3] = 3'b100;
        return r;
    endfunction

    function automatic logic [11:0] ly(input int a);
        logic [11:0] r;
        r = {4{3'b001}};
        r[3*a +: 3] = 3'b010;
        return r;
    endfunction

    localparam logic [11:0] LR = {4{3'b001}};

    task automatic push(input int c, input int app, input logic [11:0] lt,
                        input logic ps);
        ev_t e;
        e.c   = c;
        e.app = app;
        e.lt  = lt;
        e.ps  = ps;
        evq.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc - base);
        end
    endtask

    task automatic at(input int k);
        while ((cyc - base) < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        car_req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
    endtask

    // Monitor: any lamp change or phase_start pulse is an output event.
    always @(negedge clk) begin
        if (rst) begin
            prev_lt = lights;
        end else begin
            if (lights != prev_lt || phase_start) begin
                n_cmp++;
                if (evq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: cycle %0d lights %03h ps %0b app %0d, none expected",
                             cyc - base, lights, phase_start, cur_app);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    if ((cyc - base) != e.c || lights != e.lt ||
                        phase_start != e.ps || int'(cur_app) != e.app) begin
                        n_bad++;
                        $display("FAIL event: got cycle %0d lights %03h ps %0b app %0d, expected cycle %0d lights %03h ps %0b app %0d",
                                 cyc - base, lights, phase_start, cur_app,
                                 e.c, e.lt, e.ps, e.app);
                    end
                end
            end
            prev_lt = lights;
        end
    end

    initial begin
        // Idle after reset: main road green forever, single phase_start.
        push(0, 0, lg(0), 1'b1);
        do_reset();
        chk("rst_lights", int'(lights), int'(lg(0)));
        chk("rst_pending", int'(pending), 0);
        chk("rst_cur_app", int'(cur_app), 0);
        chk("rst_phase_start", int'(phase_start), 1);
        at(1);
        chk("ps_drops", int'(phase_start), 0);
        at(200);
        chk("idle_lights", int'(lights), int'(lg(0)));
        chk("idle_pending", int'(pending), 0);
        chk("idle_q_empty", evq.size(), 0);

        // Single-cycle request on approach 2, gap-out switch.
        push(0, 0, lg(0), 1'b1);
        push(42, 0, ly(0), 1'b0);
        push(67, 0, LR, 1'b0);
        push(70, 2, lg(2), 1'b1);
        // Then 3,1,0 arrive together during approach 2's green.
        push(100, 2, ly(2), 1'b0);
        push(125, 2, LR, 1'b0);
        push(128, 3, lg(3), 1'b1);
        push(158, 3, ly(3), 1'b0);
        push(183, 3, LR, 1'b0);
        push(186, 0, lg(0), 1'b1);
        push(216, 0, ly(0), 1'b0);
        push(241, 0, LR, 1'b0);
        push(244, 1, lg(1), 1'b1);
        do_reset();
        at(40);
        car_req = 4'b0100;
        at(41);
        car_req = '0;
        chk("pend2_latched", int'(pending), 4'b0100);
        at(69);
        chk("pend2_allred", int'(pending), 4'b0100);
        at(70);
        chk("pend2_cleared", int'(pending), 0);
        chk("cur_app_2", int'(cur_app), 2);
        // Owner's own sensor during its green is not latched.
        at(72);
        car_req = 4'b0100;
        at(73);
        chk("own_req_1", int'(pending), 0);
        at(75);
        car_req = '0;
        chk("own_req_2", int'(pending), 0);
        chk("own_req_lights", int'(lights), int'(lg(2)));
        at(80);
        car_req = 4'b1011;
        at(81);
        car_req = '0;
        chk("pend_multi", int'(pending), 4'b1011);
        at(128);
        chk("pend_after3", int'(pending), 4'b0011);
        at(186);
        chk("pend_after0", int'(pending), 4'b0010);
        at(244);
        chk("pend_after1", int'(pending), 0);
        at(300);
        chk("hold_1", int'(lights), int'(lg(1)));
        chk("rr_q_empty", evq.size(), 0);

        // Max-out: approach 0 sensor held while approach 1 waits.
        push(0, 0, lg(0), 1'b1);
        push(70, 0, ly(0), 1'b0);
        push(95, 0, LR, 1'b0);
        push(98, 1, lg(1), 1'b1);
        push(128, 1, ly(1), 1'b0);
        do_reset();
        car_req = 4'b0001;
        at(5);
        car_req = 4'b0011;
        at(6);
        car_req = 4'b0001;
        chk("pend1_latched", int'(pending), 4'b0010);
        at(69);
        chk("maxout_green", int'(lights), int'(lg(0)));
        at(80);
        car_req = '0;
        at(98);
        chk("own_req_in_yellow", int'(pending), 4'b0001);
        at(135);
        car_req = 4'b1000;
        at(136);
        car_req = '0;
        at(139);
        chk("pend_before_rst", int'(pending), 4'b1001);

        // Reset during approach 1 yellow.
        at(140);
        chk("yellow_1", int'(lights), int'(ly(1)));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_lights", int'(lights), int'(lg(0)));
        chk("midrst_pending", int'(pending), 0);
        chk("midrst_cur_app", int'(cur_app), 0);
        chk("midrst_cnt0", int'(phase_start), 1);
        chk("midrst_q_empty", evq.size(), 0);
        push(0, 0, lg(0), 1'b1);
        rst  = 1'b0;
        base = cyc;
        at(60);
        chk("post_rst_hold", int'(lights), int'(lg(0)));
        chk("final_q_empty", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
